// File: rtl/poly_reduce_buffer.sv
`default_nettype none
// ============================================================================
// Module      : poly_reduce_buffer
// Description : Barrett-reduces accumulated coefficient pairs into the centred
//               range, buffers one polynomial of 2^DEPTH coefficients, then
//               streams the pairs out in ascending index order on demand.
// Revision    : 1.0 - initial release
// ============================================================================
module poly_reduce_buffer #(
   parameter int DEPTH = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             set,
   input  logic             in_valid,
   input  logic [15:0]      din_1,
   input  logic [15:0]      din_2,
   input  logic [DEPTH-1:0] in_index,
   input  logic             in_done,
   input  logic             readout,
   output logic             readin_ok,
   output logic             full,
   output logic [15:0]      dout_1,
   output logic [15:0]      dout_2,
   output logic [DEPTH-1:0] out_index,
   output logic             out_valid,
   output logic             out_done
);

   localparam int PW = DEPTH - 1;  // pair-counter width
   localparam logic signed [31:0] BARRETT_V   = 32'sd20159;
   localparam logic signed [31:0] BARRETT_RND = 32'sd33554432;  // 2^25
   localparam logic [15:0]        KYBER_Q     = 16'd3329;
   // Pair indices are always even; clearing the LSB here keeps every bit of
   // in_index in use while forcing the pair alignment.
   localparam logic [DEPTH-1:0]   EVEN_MASK   = {{(DEPTH-1){1'b1}}, 1'b0};
   localparam logic [DEPTH-1:0]   ODD_BIT     = {{(DEPTH-1){1'b0}}, 1'b1};
   localparam logic [PW-1:0]      LAST_PAIR   = {PW{1'b1}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      FLUSH = 2'd2,
      OUT   = 2'd3
   } state_t;

   // Barrett quotient estimate t = (20159*a + 2^25) >>> 26; |t| <= 10.
   function automatic logic [15:0] barrett_t(input logic signed [15:0] a);
      return 16'((32'(a) * BARRETT_V + BARRETT_RND) >>> 26);
   endfunction

   // r = a - t*q; modulo-2^16 arithmetic gives the truncated result directly.
   function automatic logic [15:0] barrett_r(input logic [15:0] a,
                                             input logic [15:0] t);
      return a - t * KYBER_Q;
   endfunction

   state_t            state_q, state_d;
   logic              flush_cnt_q;
   logic              full_q;
   logic [PW-1:0]     out_cnt_q;
   logic [15:0]       dout_1_q, dout_2_q;
   logic [DEPTH-1:0]  out_index_q;
   logic              out_valid_q, out_done_q;

   logic              s1_valid_q, s2_valid_q;
   logic [DEPTH-1:0]  s1_idx_q, s2_idx_q;
   logic [15:0]       s1_a1_q, s1_a2_q, s1_t1_q, s1_t2_q;
   logic [15:0]       s2_r1_q, s2_r2_q;

   logic [15:0]       mem [2**DEPTH];

   logic              accept;
   logic              rd;
   logic              rd_last;

   assign accept  = (state_q == FILL) && in_valid;
   assign rd      = (state_q == OUT) && readout;
   assign rd_last = rd && (out_cnt_q == LAST_PAIR);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; FLUSH lasts two cycles so the last pair lands in memory.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (set)         state_d = FILL;
         FILL:    if (in_done)     state_d = FLUSH;
         FLUSH:   if (flush_cnt_q) state_d = OUT;
         OUT:     if (rd_last)     state_d = IDLE;
         default:                  state_d = IDLE;
      endcase
   end

   // Pipeline valid bits; reset drops any pair still in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
      end else begin
         s1_valid_q <= accept;
         s2_valid_q <= s1_valid_q;
      end
   end

   // Reduction datapath: stage 1 holds a and t, stage 2 holds the remainder.
   always_ff @(posedge clk) begin
      s1_idx_q <= in_index & EVEN_MASK;
      s1_a1_q  <= din_1;
      s1_a2_q  <= din_2;
      s1_t1_q  <= barrett_t(din_1);
      s1_t2_q  <= barrett_t(din_2);
      s2_idx_q <= s1_idx_q;
      s2_r1_q  <= barrett_r(s1_a1_q, s1_t1_q);
      s2_r2_q  <= barrett_r(s1_a2_q, s1_t2_q);
   end

   // Coefficient buffer, two write ports so a pair lands in a single cycle.
   always_ff @(posedge clk) begin
      if (s2_valid_q && !reset) begin
         mem[s2_idx_q]           <= s2_r1_q;
         mem[s2_idx_q | ODD_BIT] <= s2_r2_q;
      end
   end

   // Flush timer, full flag and registered readout port.
   always_ff @(posedge clk) begin
      if (reset) begin
         flush_cnt_q <= 1'b0;
         full_q      <= 1'b0;
         out_cnt_q   <= '0;
         dout_1_q    <= '0;
         dout_2_q    <= '0;
         out_index_q <= '0;
         out_valid_q <= 1'b0;
         out_done_q  <= 1'b0;
      end else begin
         flush_cnt_q <= (state_q == FLUSH) && !flush_cnt_q;
         if ((state_q == FLUSH) && flush_cnt_q) full_q <= 1'b1;
         else if (out_done_q)                   full_q <= 1'b0;
         out_valid_q <= rd;
         out_done_q  <= rd_last;
         if (rd) begin
            dout_1_q    <= mem[{out_cnt_q, 1'b0}];
            dout_2_q    <= mem[{out_cnt_q, 1'b1}];
            out_index_q <= {out_cnt_q, 1'b0};
            out_cnt_q   <= out_cnt_q + 1'b1;  // wraps to 0 after the last pair
         end
      end
   end

   assign readin_ok = (state_q == FILL);
   assign full      = full_q;
   assign dout_1    = dout_1_q;
   assign dout_2    = dout_2_q;
   assign out_index = out_index_q;
   assign out_valid = out_valid_q;
   assign out_done  = out_done_q;

endmodule
`default_nettype wire

// File: tb/tb_poly_reduce_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_poly_reduce_buffer
// Description : Self-checking bench for poly_reduce_buffer with a behavioural
//               model of the polynomial buffer contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_poly_reduce_buffer;

   localparam int DEPTH = 5;
   localparam int NP    = 2**(DEPTH-1);

   logic             clk = 1'b0;
   logic             reset, set, in_valid, in_done, readout;
   logic [15:0]      din_1, din_2;
   logic [DEPTH-1:0] in_index;
   logic             readin_ok, full, out_valid, out_done;
   logic [15:0]      dout_1, dout_2;
   logic [DEPTH-1:0] out_index;

   int n_cmp = 0;
   int n_err = 0;

   // Expected buffer contents, indexed by coefficient index.
   logic [15:0] m_mem [2**DEPTH];

   always #5 clk = ~clk;

   poly_reduce_buffer #(.DEPTH(DEPTH)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .set       (set),
      .in_valid  (in_valid),
      .din_1     (din_1),
      .din_2     (din_2),
      .in_index  (in_index),
      .in_done   (in_done),
      .readout   (readout),
      .readin_ok (readin_ok),
      .full      (full),
      .dout_1    (dout_1),
      .dout_2    (dout_2),
      .out_index (out_index),
      .out_valid (out_valid),
      .out_done  (out_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // Reduction straight from the arithmetic definition, centred mod 3329.
   function automatic logic [15:0] ref_reduce(input logic [15:0] x);
      int a, t, r;
      a = int'($signed(x));
      t = (20159 * a + 33554432) >>> 26;
      r = a - t * 3329;
      return r[15:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start();
      set = 1'b1;
      tick();
      set = 1'b0;
      chk("readin_ok_fill", 32'(readin_ok), 32'd1);
   endtask

   // One pair in FILL; readout is randomly toggled and must be ignored.
   task automatic send(input logic [DEPTH-1:0] idx, input logic [15:0] a,
                       input logic [15:0] b, input bit commit);
      int base;
      in_valid = 1'b1;
      in_index = idx;
      din_1    = a;
      din_2    = b;
      readout  = 1'($urandom_range(1, 0));
      tick();
      in_valid = 1'b0;
      chk("no_out_in_fill", 32'(out_valid), 32'd0);
      if (commit) begin
         base = int'(idx) & ~1;
         m_mem[base]   = ref_reduce(a);
         m_mem[base+1] = ref_reduce(b);
      end
   endtask

   // order: 0 ascending, 1 descending, 2 shuffled. skip: pairs left unwritten.
   task automatic fill_stream(input int order, input int gap, input bit data_is_idx,
                              input logic [NP-1:0] skip);
      int perm [NP];
      int p;
      logic [DEPTH-1:0] ix;
      for (int i = 0; i < NP; i++) perm[i] = (order == 1) ? NP-1-i : i;
      if (order == 2) begin
         for (int i = NP-1; i > 0; i--) begin
            int j, tmp;
            j = int'($urandom_range(i, 0));
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
         end
      end
      for (int i = 0; i < NP; i++) begin
         p = perm[i];
         if (!skip[p]) begin
            // LSB of the index is randomly set; the DUT must ignore it.
            ix = DEPTH'(p*2) | DEPTH'($urandom_range(1, 0));
            if (data_is_idx) send(ix, 16'(p*2), 16'(p*2+1), 1'b1);
            else             send(ix, 16'($urandom), 16'($urandom), 1'b1);
            repeat (gap) tick();
         end
      end
   endtask

   task automatic end_input(input bit with_pair, input logic [DEPTH-1:0] idx,
                            input logic [15:0] a, input logic [15:0] b);
      int base;
      readout  = 1'b0;
      in_done  = 1'b1;
      in_valid = with_pair;
      in_index = idx;
      din_1    = a;
      din_2    = b;
      tick();
      in_done  = 1'b0;
      in_valid = 1'b0;
      if (with_pair) begin
         base = int'(idx) & ~1;
         m_mem[base]   = ref_reduce(a);
         m_mem[base+1] = ref_reduce(b);
      end
      chk("readin_ok_flush", 32'(readin_ok), 32'd0);
      chk("full_flush0", 32'(full), 32'd0);
      tick();
      chk("full_flush1", 32'(full), 32'd0);
      tick();
      chk("full_rise", 32'(full), 32'd1);
   endtask

   // Drain the buffer, checking every output cycle against the model.
   task automatic drain(input bit toggle, input bit noise);
      int k, cyc;
      logic ro;
      k = 0;
      cyc = 0;
      while (k < NP && cyc < 200) begin
         ro = toggle ? 1'(cyc % 2 == 0) : 1'b1;
         readout = ro;
         if (noise) begin
            set      = 1'($urandom_range(1, 0));
            in_valid = 1'($urandom_range(1, 0));
            in_index = DEPTH'($urandom);
            din_1    = 16'($urandom);
            din_2    = 16'($urandom);
         end
         tick();
         cyc++;
         if (ro) begin
            chk("out_valid", 32'(out_valid), 32'd1);
            chk("out_index", 32'(out_index), 32'(k*2));
            chk("dout_1", 32'(dout_1), 32'(m_mem[k*2]));
            chk("dout_2", 32'(dout_2), 32'(m_mem[k*2+1]));
            chk("out_done", 32'(out_done), 32'(k == NP-1));
            chk("full_out", 32'(full), 32'd1);
            k++;
         end else begin
            chk("out_valid_idle", 32'(out_valid), 32'd0);
            chk("out_done_idle", 32'(out_done), 32'd0);
            if (k > 0) chk("dout_hold", 32'(dout_1), 32'(m_mem[(k-1)*2]));
         end
      end
      if (k < NP) chk("drain_timeout", 32'(k), 32'(NP));
      set      = 1'b0;
      readout  = 1'b0;
      in_valid = 1'b0;
      tick();
      chk("full_fall", 32'(full), 32'd0);
      chk("readin_ok_idle", 32'(readin_ok), 32'd0);
      chk("out_valid_after", 32'(out_valid), 32'd0);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_readin_ok", 32'(readin_ok), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_done", 32'(out_done), 32'd0);
      chk("rst_dout_1", 32'(dout_1), 32'd0);
      chk("rst_dout_2", 32'(dout_2), 32'd0);
      chk("rst_out_index", 32'(out_index), 32'd0);
   endtask

   // Corner inputs and their hand-derived centred remainders mod 3329.
   int          corner_in  [8] = '{1664, 1665, 3329, -3329, 5000, 32767, -32768, 0};
   int          corner_exp [8] = '{1664, -1664, 0, 0, -1658, -523, 522, 0};

   initial begin
      reset = 1'b1; set = 1'b0; in_valid = 1'b0; in_done = 1'b0; readout = 1'b0;
      din_1 = '0; din_2 = '0; in_index = '0;
      tick();
      tick();
      reset = 1'b0;
      chk_reset_outputs();

      // Reduction corners in pairs 0..3, random data elsewhere.
      start();
      for (int k = 0; k < 4; k++)
         send(DEPTH'(k*2), 16'(corner_in[2*k]), 16'(corner_in[2*k+1]), 1'b1);
      fill_stream(0, 0, 1'b0, 16'h000F);
      for (int k = 0; k < 8; k++) m_mem[k] = 16'(corner_exp[k]);
      end_input(1'b0, '0, '0, '0);
      drain(1'b0, 1'b0);

      // Full back-to-back stream, data equal to index.
      start();
      fill_stream(0, 0, 1'b1, '0);
      end_input(1'b0, '0, '0, '0);
      drain(1'b0, 1'b0);

      // Gapped reverse-order input, toggling readout.
      start();
      fill_stream(1, 2, 1'b0, '0);
      end_input(1'b0, '0, '0, '0);
      drain(1'b1, 1'b0);

      // Last pair arrives with in_done; ignored inputs hammered during OUT.
      start();
      fill_stream(2, 0, 1'b0, 16'h8000);
      end_input(1'b1, DEPTH'(30), 16'd5000, 16'(-5000));
      m_mem[30] = 16'(-1658);
      m_mem[31] = 16'd1658;
      drain(1'b0, 1'b1);

      // Reset mid-FILL: pairs 0 and 2 commit, 4 and 6 are still in flight.
      start();
      send(DEPTH'(0), 16'($urandom), 16'($urandom), 1'b1);
      send(DEPTH'(2), 16'($urandom), 16'($urandom), 1'b1);
      send(DEPTH'(4), 16'($urandom), 16'($urandom), 1'b0);
      send(DEPTH'(6), 16'($urandom), 16'($urandom), 1'b0);
      readout = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_reset_outputs();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_index = DEPTH'(4 + 2*(i % 2));
         din_1    = 16'($urandom);
         din_2    = 16'($urandom);
         tick();
         chk("readin_ok_after_rst", 32'(readin_ok), 32'd0);
      end
      in_valid = 1'b0;
      // Slots 4..7 are left unwritten and must still hold the older stream.
      start();
      fill_stream(2, 0, 1'b0, 16'h000C);
      end_input(1'b0, '0, '0, '0);
      drain(1'b1, 1'b1);

      // Final fully random stream.
      start();
      fill_stream(2, 1, 1'b0, '0);
      end_input(1'b0, '0, '0, '0);
      drain(1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global time limit so the run always terminates.
   initial begin
      #200000;
      n_err++;
      $display("FAIL timeout: simulation did not finish, required completion before 200000");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
